// File: rtl/spi_stream_tx_pkg.sv
// Shared types and helpers for the streaming SPI transmitter.
// FSM state encoding and counter sizing used by the top and its phase timer.
package spi_stream_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_LATCH  = 2'd3
  } spi_state_e;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/spi_stream_tx_phase_timer.sv
// Loadable down-counter that flags when it has reached zero.
// Times the SCLK half-periods and the end-of-frame latch interval.
module spi_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             spi_clk,
  input  logic             spi_reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/spi_stream_tx.sv
// Write-only SPI master streaming valid/ready words to an LED strip.
// Back-to-back words share no gap; a frame ends with an idle latch interval.
module spi_stream_tx
  import spi_stream_tx_pkg::*;
#(
  parameter int   DATA_WIDTH   = 8,
  parameter int   HALF_PERIOD  = 6,
  parameter logic MSB_FIRST    = 1'b1,
  parameter logic CPOL         = 1'b0,
  parameter int   LATCH_CYCLES = 600
) (
  input  logic                  spi_clk,
  input  logic                  spi_reset_n,
  input  logic                  spi_in_valid,
  input  logic [DATA_WIDTH-1:0] spi_in_data,
  input  logic                  spi_in_last,
  output logic                  spi_in_ready,
  output logic                  spi_output_data,
  output logic                  spi_output_clock,
  output logic                  spi_busy,
  output logic                  spi_frame_done
);

  localparam int TW = (cnt_width(HALF_PERIOD) > cnt_width(LATCH_CYCLES)) ?
                      cnt_width(HALF_PERIOD) : cnt_width(LATCH_CYCLES);
  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [TW-1:0] PH_LOAD  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] LAT_LOAD = TW'((LATCH_CYCLES > 0) ? LATCH_CYCLES - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[DATA_WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  spi_state_e            state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BW-1:0]         bit_cnt_r;
  logic                  last_r;
  logic                  data_r;
  logic                  sclk_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  timer_done_s;
  logic                  timer_load_s;
  logic [TW-1:0]         timer_value_s;
  logic                  word_end_s;
  logic                  ready_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] shift_next_s;

  // Ready is decoded from registered state only: idle, or the closing cycle of a non-final word.
  assign word_end_s = (state_r == ST_ACTIVE) && timer_done_s && (bit_cnt_r == LAST_BIT);
  assign ready_s    = (state_r == ST_IDLE) || (word_end_s && !last_r);
  assign accept_s   = spi_in_valid && ready_s;

  // Next shift value and timer reload for the coming phase.
  always_comb begin
    shift_next_s  = shift_r;
    timer_load_s  = 1'b0;
    timer_value_s = PH_LOAD;
    if (MSB_FIRST) begin
      shift_next_s = shift_r << 1'b1;
    end else begin
      shift_next_s = shift_r >> 1'b1;
    end
    if (accept_s) begin
      timer_load_s = 1'b1;
    end else if (((state_r == ST_SETUP) || (state_r == ST_ACTIVE)) && timer_done_s) begin
      timer_load_s = 1'b1;
    end else begin
      timer_load_s = 1'b0;
    end
    if (word_end_s && last_r) begin
      timer_value_s = LAT_LOAD;
    end else begin
      timer_value_s = PH_LOAD;
    end
  end

  spi_phase_timer #(
    .WIDTH(TW)
  ) u_timer (
    .spi_clk    (spi_clk),
    .spi_reset_n(spi_reset_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .done       (timer_done_s)
  );

  // Transfer FSM with shifter and registered pin drivers.
  always_ff @(posedge spi_clk or negedge spi_reset_n) begin
    if (!spi_reset_n) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      last_r    <= 1'b0;
      data_r    <= 1'b0;
      sclk_r    <= CPOL;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk_r <= CPOL;
          if (accept_s) begin
            shift_r   <= spi_in_data;
            last_r    <= spi_in_last;
            data_r    <= pick_bit(spi_in_data);
            bit_cnt_r <= {BW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_SETUP;
          end else begin
            data_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (timer_done_s) begin
            sclk_r  <= ~CPOL;
            state_r <= ST_ACTIVE;
          end else begin
            sclk_r <= CPOL;
          end
        end
        ST_ACTIVE: begin
          if (!timer_done_s) begin
            sclk_r <= ~CPOL;
          end else if (bit_cnt_r != LAST_BIT) begin
            sclk_r    <= CPOL;
            shift_r   <= shift_next_s;
            data_r    <= pick_bit(shift_next_s);
            bit_cnt_r <= bit_cnt_r + BW'(1);
            state_r   <= ST_SETUP;
          end else if (!last_r) begin
            sclk_r <= CPOL;
            if (spi_in_valid) begin
              shift_r   <= spi_in_data;
              last_r    <= spi_in_last;
              data_r    <= pick_bit(spi_in_data);
              bit_cnt_r <= {BW{1'b0}};
              state_r   <= ST_SETUP;
            end else begin
              data_r  <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            sclk_r <= CPOL;
            data_r <= 1'b0;
            if (LATCH_CYCLES == 0) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          sclk_r <= CPOL;
          data_r <= 1'b0;
          if (timer_done_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          shift_r   <= {DATA_WIDTH{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
          last_r    <= 1'b0;
          data_r    <= 1'b0;
          sclk_r    <= CPOL;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign spi_in_ready     = ready_s;
  assign spi_output_data  = data_r;
  assign spi_output_clock = sclk_r;
  assign spi_busy         = busy_r;
  assign spi_frame_done   = done_r;

endmodule

// File: tb/tb_spi_stream_tx.sv
// Self-checking bench for spi_stream_tx: three configurations against a cycle-index reference model.
module tb_spi_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        vld [3];
  logic [31:0] dat [3];
  logic        lst [3];
  logic        rdy [3];
  logic        mosi [3];
  logic        sclk [3];
  logic        busy [3];
  logic        fd [3];

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_stream_tx u0 (
    .spi_clk(clk), .spi_reset_n(rst_n), .spi_in_valid(vld[0]), .spi_in_data(dat[0][7:0]),
    .spi_in_last(lst[0]), .spi_in_ready(rdy[0]), .spi_output_data(mosi[0]),
    .spi_output_clock(sclk[0]), .spi_busy(busy[0]), .spi_frame_done(fd[0]));

  spi_stream_tx #(.DATA_WIDTH(24), .MSB_FIRST(1'b0), .CPOL(1'b1), .LATCH_CYCLES(20)) u1 (
    .spi_clk(clk), .spi_reset_n(rst_n), .spi_in_valid(vld[1]), .spi_in_data(dat[1][23:0]),
    .spi_in_last(lst[1]), .spi_in_ready(rdy[1]), .spi_output_data(mosi[1]),
    .spi_output_clock(sclk[1]), .spi_busy(busy[1]), .spi_frame_done(fd[1]));

  spi_stream_tx #(.HALF_PERIOD(1), .LATCH_CYCLES(0)) u2 (
    .spi_clk(clk), .spi_reset_n(rst_n), .spi_in_valid(vld[2]), .spi_in_data(dat[2][7:0]),
    .spi_in_last(lst[2]), .spi_in_ready(rdy[2]), .spi_output_data(mosi[2]),
    .spi_output_clock(sclk[2]), .spi_busy(busy[2]), .spi_frame_done(fd[2]));

  function automatic int p_dw(input int i);
    return (i == 1) ? 24 : 8;
  endfunction
  function automatic int p_hp(input int i);
    return (i == 2) ? 1 : 6;
  endfunction
  function automatic bit p_msb(input int i);
    return (i == 1) ? 1'b0 : 1'b1;
  endfunction
  function automatic bit p_cpol(input int i);
    return (i == 1) ? 1'b1 : 1'b0;
  endfunction
  function automatic int p_lc(input int i);
    return (i == 0) ? 600 : ((i == 1) ? 20 : 0);
  endfunction

  // Reference model: m_k is the 1-based cycle index inside the word being sent.
  bit          m_str [3];
  bit          m_lt [3];
  bit          m_fd [3];
  bit          m_last [3];
  int          m_k [3];
  int          m_lat [3];
  int          m_acc [3];
  logic [31:0] m_w [3];

  initial for (int i = 0; i < 3; i++) m_acc[i] = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_str[i] <= 1'b0; m_lt[i] <= 1'b0; m_fd[i] <= 1'b0; m_k[i] <= 0; m_lat[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_fd[i] <= 1'b0;
        if (m_lt[i]) begin
          if (m_lat[i] > 1) m_lat[i] <= m_lat[i] - 1;
          else begin m_lt[i] <= 1'b0; m_fd[i] <= 1'b1; end
        end else if (m_str[i] && m_k[i] < p_dw(i) * 2 * p_hp(i)) begin
          m_k[i] <= m_k[i] + 1;
        end else if (m_str[i] && m_last[i]) begin
          m_str[i] <= 1'b0;
          if (p_lc(i) > 0) begin m_lt[i] <= 1'b1; m_lat[i] <= p_lc(i); end
          else m_fd[i] <= 1'b1;
        end else if (vld[i]) begin
          m_w[i] <= dat[i]; m_last[i] <= lst[i]; m_k[i] <= 1; m_str[i] <= 1'b1;
          m_acc[i] <= m_acc[i] + 1;
        end else begin
          m_str[i] <= 1'b0;
        end
      end
    end
  end

  function automatic bit e_rdy(input int i);
    if (m_lt[i]) return 1'b0;
    else if (m_str[i]) return (m_k[i] == p_dw(i) * 2 * p_hp(i)) && !m_last[i];
    else return 1'b1;
  endfunction
  function automatic bit e_mosi(input int i);
    int b;
    if (!m_str[i]) return 1'b0;
    b = (m_k[i] - 1) / (2 * p_hp(i));
    return p_msb(i) ? m_w[i][p_dw(i) - 1 - b] : m_w[i][b];
  endfunction
  function automatic bit e_sclk(input int i);
    if (m_str[i] && ((m_k[i] - 1) % (2 * p_hp(i))) >= p_hp(i)) return !p_cpol(i);
    else return p_cpol(i);
  endfunction

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("ready", i, rdy[i], e_rdy(i));
      chk("mosi", i, mosi[i], e_mosi(i));
      chk("sclk", i, sclk[i], e_sclk(i));
      chk("busy", i, busy[i], m_str[i] || m_lt[i]);
      chk("frame_done", i, fd[i], m_fd[i]);
    end
  end

  task automatic send(input int i, input logic [31:0] d, input logic l, input bit keep);
    int n0;
    bit ok;
    n0 = m_acc[i];
    ok = 1'b0;
    dat[i] = d; lst[i] = l; vld[i] = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (m_acc[i] != n0) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", i, ok, 1);
    if (!keep) vld[i] = 1'b0;
  endtask

  task automatic watch(input int i, input int maxc, output int rises, output logic [31:0] bits,
                       output int fd_at, output int fd_cnt, output int hs, output int act,
                       output int first_act, output int last_act, output int rb);
    logic a;
    logic prev;
    a = !p_cpol(i);
    prev = sclk[i];
    rises = 0; bits = 32'h0; fd_at = 0; fd_cnt = 0; hs = 0; act = 0;
    first_act = -1; last_act = -1; rb = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (sclk[i] == a) begin
        act++;
        if (first_act < 0) first_act = c;
        last_act = c;
        if (prev != a) begin rises++; bits = {bits[30:0], mosi[i]}; end
      end
      prev = sclk[i];
      if (vld[i] && rdy[i]) hs++;
      if (busy[i] && rdy[i]) rb++;
      if (fd[i]) begin fd_cnt++; if (fd_at == 0) fd_at = c; end
      if (fd_at != 0 && c >= fd_at + 2) break;
      @(negedge clk);
    end
  endtask

  int          r, fa, fc, hs, act, f1, l1, rb;
  logic [31:0] bits;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin vld[i] = 1'b0; dat[i] = 32'h0; lst[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_sclk_cpol0", 0, sclk[0], 0);
    chk("rst_sclk_cpol1", 1, sclk[1], 1);
    chk("rst_busy", 0, busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single 0xA5 frame with defaults
    send(0, 32'hA5, 1'b1, 1'b0);
    watch(0, 800, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t1_rises", 0, r, 8);
    chk("t1_bits", 0, bits, 32'hA5);
    chk("t1_fd_at", 0, fa, 697);
    chk("t1_fd_cnt", 0, fc, 1);

    // 2: three words back-to-back
    send(0, 32'h01, 1'b0, 1'b1);
    fork
      begin send(0, 32'h80, 1'b0, 1'b1); send(0, 32'hFF, 1'b1, 1'b0); end
      watch(0, 1200, r, bits, fa, fc, hs, act, f1, l1, rb);
    join
    chk("t2_rises", 0, r, 24);
    chk("t2_bits", 0, bits, 32'h0180FF);
    chk("t2_active_cycles", 0, act, 144);
    chk("t2_active_span", 0, l1 - f1 + 1, 282);
    chk("t2_handshakes", 0, hs, 2);
    chk("t2_fd_cnt", 0, fc, 1);

    // 3: LSB first, CPOL=1, 24-bit word
    send(1, 32'h000001, 1'b1, 1'b0);
    chk("t3_sclk_idle_high", 1, sclk[1], 1);
    watch(1, 400, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t3_falls", 1, r, 24);
    chk("t3_bits", 1, bits, 32'h800000);
    chk("t3_fd_at", 1, fa, 309);
    chk("t3_sclk_after", 1, sclk[1], 1);

    // 4: word without last, then valid dropped
    send(0, 32'h3C, 1'b0, 1'b0);
    watch(0, 130, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t4_fd_cnt", 0, fc, 0);
    chk("t4_bits", 0, bits, 32'h3C);
    chk("t4_busy_low", 0, busy[0], 0);
    chk("t4_mosi_low", 0, mosi[0], 0);
    send(0, 32'hC3, 1'b1, 1'b0);
    watch(0, 800, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t4_restart_bits", 0, bits, 32'hC3);
    chk("t4_restart_fd", 0, fc, 1);

    // 5: asynchronous reset mid-bit of word 2
    send(0, 32'h5A, 1'b0, 1'b1);
    send(0, 32'h96, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t5_pre_sclk", 0, sclk[0], 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_sclk", 0, sclk[0], 0);
    chk("t5_rst_mosi", 0, mosi[0], 0);
    chk("t5_rst_busy", 0, busy[0], 0);
    chk("t5_rst_ready", 0, rdy[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 32'h69, 1'b1, 1'b0);
    watch(0, 800, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t5_bits", 0, bits, 32'h69);
    chk("t5_fd_at", 0, fa, 697);

    // 6: HALF_PERIOD=1, no latch interval
    send(2, 32'hB4, 1'b1, 1'b0);
    watch(2, 40, r, bits, fa, fc, hs, act, f1, l1, rb);
    chk("t6_rises", 2, r, 8);
    chk("t6_bits", 2, bits, 32'hB4);
    chk("t6_fd_at", 2, fa, 17);
    chk("t6_ready_busy", 2, rb, 0);
    chk("t6_fd_cnt", 2, fc, 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
